// File: rtl/md5_pkg.sv
// Shared MD5 definitions for the step engine, its benches and the upstream
// padding stage: FSM state encoding, step count, per-round rotate amounts,
// the standard initial chaining value and a 32-bit rotate helper.
package md5_pkg;

  localparam int         NSTEPS    = 64;
  localparam logic [5:0] LAST_STEP = 6'(NSTEPS - 1);

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;
  // Packed like h_in/h_out: A in the low lane, D in the high lane.
  localparam logic [127:0] MD5_IV = {IV_D, IV_C, IV_B, IV_A};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Rotate amount for a step, selected by round (cnt[5:4]) and cnt[1:0].
  function automatic logic [4:0] shift_amt(input logic [1:0] rnd, input logic [1:0] idx);
    logic [4:0] s;
    s = 5'd0;
    case ({rnd, idx})
      4'h0: s = 5'd7;
      4'h1: s = 5'd12;
      4'h2: s = 5'd17;
      4'h3: s = 5'd22;
      4'h4: s = 5'd5;
      4'h5: s = 5'd9;
      4'h6: s = 5'd14;
      4'h7: s = 5'd20;
      4'h8: s = 5'd4;
      4'h9: s = 5'd11;
      4'ha: s = 5'd16;
      4'hb: s = 5'd23;
      4'hc: s = 5'd6;
      4'hd: s = 5'd10;
      4'he: s = 5'd15;
      4'hf: s = 5'd21;
      default: s = 5'd0;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] s);
    // A 6-bit right-shift amount keeps s=0 well defined (x >> 32 is zero).
    return (x << s) | (x >> (6'd32 - {1'b0, s}));
  endfunction

endpackage

// File: rtl/md5_step_engine_k_rom.sv
// MD5 additive constant table: K[i] = floor(abs(sin(i+1)) * 2^32).
// Ports:
//   step_idx  in   6  step number 0..63
//   k_out     out 32  constant for that step (combinational)
module md5_step_engine_k_rom (
  input  logic [5:0]  step_idx,
  output logic [31:0] k_out
);

  always_comb begin
    k_out = 32'h0;
    case (step_idx)
      6'd0:  k_out = 32'hd76aa478;
      6'd1:  k_out = 32'he8c7b756;
      6'd2:  k_out = 32'h242070db;
      6'd3:  k_out = 32'hc1bdceee;
      6'd4:  k_out = 32'hf57c0faf;
      6'd5:  k_out = 32'h4787c62a;
      6'd6:  k_out = 32'ha8304613;
      6'd7:  k_out = 32'hfd469501;
      6'd8:  k_out = 32'h698098d8;
      6'd9:  k_out = 32'h8b44f7af;
      6'd10: k_out = 32'hffff5bb1;
      6'd11: k_out = 32'h895cd7be;
      6'd12: k_out = 32'h6b901122;
      6'd13: k_out = 32'hfd987193;
      6'd14: k_out = 32'ha679438e;
      6'd15: k_out = 32'h49b40821;
      6'd16: k_out = 32'hf61e2562;
      6'd17: k_out = 32'hc040b340;
      6'd18: k_out = 32'h265e5a51;
      6'd19: k_out = 32'he9b6c7aa;
      6'd20: k_out = 32'hd62f105d;
      6'd21: k_out = 32'h02441453;
      6'd22: k_out = 32'hd8a1e681;
      6'd23: k_out = 32'he7d3fbc8;
      6'd24: k_out = 32'h21e1cde6;
      6'd25: k_out = 32'hc33707d6;
      6'd26: k_out = 32'hf4d50d87;
      6'd27: k_out = 32'h455a14ed;
      6'd28: k_out = 32'ha9e3e905;
      6'd29: k_out = 32'hfcefa3f8;
      6'd30: k_out = 32'h676f02d9;
      6'd31: k_out = 32'h8d2a4c8a;
      6'd32: k_out = 32'hfffa3942;
      6'd33: k_out = 32'h8771f681;
      6'd34: k_out = 32'h6d9d6122;
      6'd35: k_out = 32'hfde5380c;
      6'd36: k_out = 32'ha4beea44;
      6'd37: k_out = 32'h4bdecfa9;
      6'd38: k_out = 32'hf6bb4b60;
      6'd39: k_out = 32'hbebfbc70;
      6'd40: k_out = 32'h289b7ec6;
      6'd41: k_out = 32'heaa127fa;
      6'd42: k_out = 32'hd4ef3085;
      6'd43: k_out = 32'h04881d05;
      6'd44: k_out = 32'hd9d4d039;
      6'd45: k_out = 32'he6db99e5;
      6'd46: k_out = 32'h1fa27cf8;
      6'd47: k_out = 32'hc4ac5665;
      6'd48: k_out = 32'hf4292244;
      6'd49: k_out = 32'h432aff97;
      6'd50: k_out = 32'hab9423a7;
      6'd51: k_out = 32'hfc93a039;
      6'd52: k_out = 32'h655b59c3;
      6'd53: k_out = 32'h8f0ccc92;
      6'd54: k_out = 32'hffeff47d;
      6'd55: k_out = 32'h85845dd1;
      6'd56: k_out = 32'h6fa87e4f;
      6'd57: k_out = 32'hfe2ce6e0;
      6'd58: k_out = 32'ha3014314;
      6'd59: k_out = 32'h4e0811a1;
      6'd60: k_out = 32'hf7537e82;
      6'd61: k_out = 32'hbd3af235;
      6'd62: k_out = 32'h2ad7d2bb;
      6'd63: k_out = 32'heb86d391;
      default: k_out = 32'h0;
    endcase
  end

endmodule

// File: rtl/md5_step_engine.sv
// Iterative MD5 compression: one 512-bit block plus a 128-bit chaining value
// in, updated chaining value out. One MD5 step per clock, 64 steps per block.
// Ports:
//   clk       in    1  system clock, rising edge
//   rst       in    1  synchronous active-high reset (aborts a block silently)
//   start     in    1  request, sampled only while busy=0
//   block_in  in  512  M[i] = block_in[32i+31:32i]
//   h_in      in  128  chaining input, A=[31:0] .. D=[127:96]
//   busy      out   1  block in progress
//   done      out   1  one-cycle pulse, h_out valid
//   h_out     out 128  result, held until the next done
//
// state   | meaning
// IDLE    | waiting for start; h_out holds the last result
// RUN     | one compression step per clock, cnt = step 0..63
// FIN     | add saved chaining value, pulse done
module md5_step_engine
  import md5_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic [127:0] h_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] h_out
);

  state_e             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [15:0][31:0]  m_q, m_d;
  logic [127:0]       hsave_q, hsave_d;
  logic [31:0]        a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [127:0]       h_out_q, h_out_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [31:0] k_val;
  logic [31:0] f_val;
  logic [3:0]  g_idx;
  logic [4:0]  s_amt;
  logic [31:0] step_sum;

  md5_step_engine_k_rom u_k_rom (
    .step_idx (cnt_q),
    .k_out    (k_val)
  );

  // Round function and message index. The g formulas only need cnt mod 16,
  // so they are evaluated in 4 bits and wrap naturally.
  always_comb begin
    f_val = 32'h0;
    g_idx = 4'h0;
    case (cnt_q[5:4])
      2'd0: begin
        f_val = (b_q & c_q) | (~b_q & d_q);
        g_idx = cnt_q[3:0];
      end
      2'd1: begin
        f_val = (d_q & b_q) | (~d_q & c_q);
        g_idx = cnt_q[3:0] * 4'd5 + 4'd1;
      end
      2'd2: begin
        f_val = b_q ^ c_q ^ d_q;
        g_idx = cnt_q[3:0] * 4'd3 + 4'd5;
      end
      default: begin
        f_val = c_q ^ (b_q | ~d_q);
        g_idx = cnt_q[3:0] * 4'd7;
      end
    endcase
    s_amt    = shift_amt(cnt_q[5:4], cnt_q[1:0]);
    step_sum = a_q + f_val + k_val + m_q[g_idx];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    hsave_d = hsave_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    h_out_d = h_out_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d     = block_in;
          hsave_d = h_in;
          a_d     = h_in[31:0];
          b_d     = h_in[63:32];
          c_d     = h_in[95:64];
          d_d     = h_in[127:96];
          cnt_d   = 6'd0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d   = d_q;
        d_d   = c_q;
        c_d   = b_q;
        b_d   = b_q + rotl32(step_sum, s_amt);
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_STEP) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        h_out_d = {hsave_q[127:96] + d_q, hsave_q[95:64] + c_q,
                   hsave_q[63:32]  + b_q, hsave_q[31:0]  + a_q};
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      m_q     <= '0;
      hsave_q <= '0;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      c_q     <= 32'h0;
      d_q     <= 32'h0;
      h_out_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      hsave_q <= hsave_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      h_out_q <= h_out_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign h_out = h_out_q;

endmodule

// File: doc/md5_step_engine.md
Name: md5_step_engine

Overview:
- Iterative MD5 compression core: one 512-bit message block plus a 128-bit chaining value in, updated 128-bit chaining value out.
- Drives the 6-bit step index into the K_ROM constant table and consumes its 32-bit K output, performing one MD5 step per clock (64 steps per block).
- Sits between the padding/block-assembly stage upstream and the digest register/output formatter downstream.

Parameters:
- NSTEPS, 64, number of compression steps; fixed by MD5 and not to be overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request; sampled only when busy=0.
- block_in  input  512  message words; M[i] = block_in[32i+31:32i], i=0..15, already little-endian word-assembled (byte 4i at bits [32i+7:32i]).
- h_in  input  128  chaining input; A=[31:0], B=[63:32], C=[95:64], D=[127:96].
- busy  output  1  high while a block is being processed.
- done  output  1  one-cycle pulse when h_out is valid.
- h_out  output  128  updated chaining value; same packing as h_in; held until the next done.

Behaviour:
- Reset (rst=1 at an edge): state IDLE, cnt=0, busy=0, done=0, h_out=0, working registers=0. Applies mid-operation and aborts the block with no done pulse.
- States: IDLE -> RUN -> FIN -> IDLE.
- IDLE, start=1 at edge E0: latch block_in into M[0..15], h_in into H_save and into A/B/C/D. Set cnt=0, busy=1, state=RUN.
- RUN: cnt drives K_ROM combinationally. At each edge:
  - F = (B&C)|(~B&D) for cnt 0-15; (D&B)|(~D&C) for 16-31; B^C^D for 32-47; C^(B|~D) for 48-63.
  - g = cnt for 0-15; (5cnt+1) mod 16 for 16-31; (3cnt+5) mod 16 for 32-47; (7cnt) mod 16 for 48-63.
  - s by round, indexed by cnt mod 4: {7,12,17,22}, {5,9,14,20}, {4,11,16,23}, {6,10,15,21}.
  - Register update: A<=D, D<=C, C<=B, B<=B+rotl32(A+F+K+M[g], s).
  - cnt increments. When cnt=63, go to FIN after the update (cnt wraps to 0).
- All arithmetic is modulo 2^32. Carries are discarded and no width growth is kept.
- FIN, one cycle: h_out <= {H_save.D+D, H_save.C+C, H_save.B+B, H_save.A+A} (each lane modulo 2^32). done<=1, busy<=0, state=IDLE.
- done falls on the next edge unless the next block completes in the same cycle, which is impossible given the latency.
- Latency: start sampled at E0, steps at E1..E64, done high after E65. Back-to-back start is accepted on the cycle done is high, so throughput is one block per 66 cycles.
- start while busy=1 is ignored with no queueing. block_in/h_in need only be valid in the start cycle.
- start and rst in the same cycle: reset wins.

Decomposition:
- md5_pkg holds the state encoding (IDLE/RUN/FIN), the shift-amount table and the standard IV constants (67452301, efcdab89, 98badcfe, 10325476) used by benches and the upstream stage.
- Sub-module: the existing K_ROM is instantiated as the constant table (cnt -> K). F/g/s selection stays inline.

Test Plan:
- Empty message: M0=00000080, M1..M15=0, h_in = IV -> 65 cycles later done=1 with A=d98c1dd4, B=04b2008f, C=980980e9, D=7e42f8ec (MD5 d41d8cd98f00b204e9800998ecf8427e).
- "abc": M0=80636261, M14=00000018, others 0, h_in = IV -> A=98500190, B=b04fd23c, C=7d3f96d6, D=727fe128.
- Pulse start again at cycle 10 while busy -> ignored; single done at cycle 65 with an unchanged result. Then back-to-back start on the done cycle -> second done exactly 66 cycles later.
- Assert rst at step 30 -> busy=0, done=0, h_out=0 next cycle, no done pulse. A fresh start then gives the correct "abc" result.
- Chaining: feed the first block's h_out as h_in for a second block of a 64-byte message ("a" x 64 plus padding block) -> final digest matches the software MD5 (014842d480b571495a4a0363793f7367).
- Wrap check: h_in = ffffffff in all lanes with the empty block -> h_out lanes equal the lane sums modulo 2^32, compared against a reference model.
